// File: rtl/cpu_pkg.sv
// cpu_pkg: shared instruction word types and constants for the datapath
package cpu_pkg;
    localparam int INSTR_W = 32;
    typedef logic [INSTR_W-1:0] instr_t;
    localparam instr_t NOP_WORD = '0;
endpackage

// File: rtl/instruction_queue_mem.sv
// instruction_queue_mem: DEPTH x DATA_W register array, sync write, async read
module instruction_queue_mem #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem_q [DEPTH];

    // Storage needs no reset; only entries between the pointers are ever read as valid
    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/instruction_queue.sv
// instruction_queue: FIFO-buffered instruction register with tri-state head output
module instruction_queue
    import cpu_pkg::*;
#(
    parameter int                DATA_W   = INSTR_W,
    parameter int                DEPTH    = 4,
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(cpu_pkg::NOP_WORD)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_W-1:0]          BUSC_DATA_IN,
    input  logic                       busc_in,
    input  logic                       instrn_next,
    input  logic                       flush,
    input  logic                       instrn_out,
    output logic [DATA_W-1:0]          INSTRN_DATA_OUT,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [AW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              push_ok, pop_ok, push_drop;
    logic [DATA_W-1:0] head;

    // A full queue still accepts a push when a pop frees the head slot in the same edge
    assign push_ok   = busc_in && (!full || instrn_next);
    assign push_drop = busc_in && full && !instrn_next;
    assign pop_ok    = instrn_next && !empty;

    instruction_queue_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_mem (
        .clk   (clk),
        .we    (push_ok && !flush && !rst),
        .waddr (wr_ptr_q),
        .wdata (BUSC_DATA_IN),
        .raddr (rd_ptr_q),
        .rdata (head)
    );

    // Next pointer/count/overflow state; flush discards any same-edge push or pop
    always_comb begin
        rd_ptr_d   = flush ? '0 : rd_ptr_q + AW'(pop_ok);
        wr_ptr_d   = flush ? '0 : wr_ptr_q + AW'(push_ok);
        count_d    = flush ? '0 : count_q + CW'(push_ok) - CW'(pop_ok);
        overflow_d = overflow_q || (push_drop && !flush);
    end

    // Queue state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign count    = count_q;
    assign empty    = count_q == '0;
    assign full     = count_q == CW'(DEPTH);
    assign overflow = overflow_q;

    assign INSTRN_DATA_OUT = instrn_out ? (empty ? NOP_WORD : head) : {DATA_W{1'bz}};
endmodule

// File: tb/tb_instruction_queue.sv
// tb_instruction_queue: scoreboard-driven bench for instruction_queue
module tb_instruction_queue;
    logic        clk = 0;
    logic        rst = 1;
    logic [31:0] BUSC_DATA_IN = '0;
    logic        busc_in = 0, instrn_next = 0, flush = 0, instrn_out = 1;
    wire  [31:0] INSTRN_DATA_OUT;
    logic        empty, full, overflow;
    logic [2:0]  count;

    int passed = 0;
    int total  = 0;
    logic [31:0] sb[$];
    logic        ovf_m = 0;

    instruction_queue dut (
        .clk(clk), .rst(rst), .BUSC_DATA_IN(BUSC_DATA_IN), .busc_in(busc_in),
        .instrn_next(instrn_next), .flush(flush), .instrn_out(instrn_out),
        .INSTRN_DATA_OUT(INSTRN_DATA_OUT), .empty(empty), .full(full),
        .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_head();
        return sb.size() > 0 ? sb[0] : 32'h0;
    endfunction

    task automatic cycle(input logic p, input logic [31:0] d, input logic n, input logic f, input logic r);
        bit was_full = sb.size() == 4;
        bit pop_ok   = n && sb.size() > 0;
        bit push_ok  = p && (!was_full || n);
        busc_in = p; BUSC_DATA_IN = d; instrn_next = n; flush = f; rst = r;
        if (r) begin
            sb.delete(); ovf_m = 0;
        end else if (f) begin
            sb.delete();
        end else begin
            if (p && was_full && !n) ovf_m = 1;
            if (pop_ok) void'(sb.pop_front());
            if (push_ok) sb.push_back(d);
        end
        @(posedge clk); #1;
        busc_in = 0; instrn_next = 0; flush = 0; rst = 0;
    endtask

    task automatic test_reset();
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);
        total++; if (count !== 3'd0) $display("FAIL reset_count: got %0d want 0", count); else passed++;
        total++; if (empty !== 1'b1 || full !== 1'b0) $display("FAIL reset_flags: got empty=%b full=%b want 1 0", empty, full); else passed++;
        total++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b want 0", overflow); else passed++;
        total++; if (INSTRN_DATA_OUT !== 32'h0) $display("FAIL reset_nop: got %h want 00000000", INSTRN_DATA_OUT); else passed++;
    endtask

    task automatic test_fifo_order();
        logic [31:0] vals [3] = '{32'hA1, 32'hB2, 32'hC3};
        for (int i = 0; i < 3; i++) begin
            cycle(1, vals[i], 0, 0, 0);
            total++; if (INSTRN_DATA_OUT !== 32'hA1) $display("FAIL push_head%0d: got %h want a1", i, INSTRN_DATA_OUT); else passed++;
            total++; if (count !== 3'(i + 1)) $display("FAIL push_count%0d: got %0d want %0d", i, count, i + 1); else passed++;
        end
        instrn_out = 0; #1;
        total++; if (INSTRN_DATA_OUT === 32'hA1) $display("FAIL out_disabled: got %h want not driven", INSTRN_DATA_OUT); else passed++;
        instrn_out = 1; #1;
        total++; if (INSTRN_DATA_OUT !== 32'hA1) $display("FAIL out_enabled: got %h want a1", INSTRN_DATA_OUT); else passed++;
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 1, 0, 0);
            total++; if (INSTRN_DATA_OUT !== exp_head()) $display("FAIL pop_head%0d: got %h want %h", i, INSTRN_DATA_OUT, exp_head()); else passed++;
            total++; if (count !== 3'(sb.size()) || empty !== (sb.size() == 0)) $display("FAIL pop_count%0d: got %0d/%b want %0d", i, count, empty, sb.size()); else passed++;
        end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 4; i++) cycle(1, 32'(i * 'h11), 0, 0, 0);
        total++; if (full !== 1'b1 || count !== 3'd4) $display("FAIL fill: got full=%b count=%0d want 1 4", full, count); else passed++;
        total++; if (overflow !== 1'b0) $display("FAIL fill_ovf: got %b want 0", overflow); else passed++;
        cycle(1, 32'h55, 0, 0, 0);
        total++; if (overflow !== ovf_m || count !== 3'd4) $display("FAIL drop: got ovf=%b count=%0d want 1 4", overflow, count); else passed++;
        total++; if (INSTRN_DATA_OUT !== 32'h11) $display("FAIL drop_head: got %h want 11", INSTRN_DATA_OUT); else passed++;
        cycle(1, 32'h66, 1, 0, 0);
        total++; if (INSTRN_DATA_OUT !== 32'h22 || count !== 3'd4 || full !== 1'b1) $display("FAIL full_pushpop: got %h/%0d want 22/4", INSTRN_DATA_OUT, count); else passed++;
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 1, 0, 0);
            total++; if (INSTRN_DATA_OUT !== exp_head() || count !== 3'(sb.size())) $display("FAIL drain%0d: got %h/%0d want %h/%0d", i, INSTRN_DATA_OUT, count, exp_head(), sb.size()); else passed++;
        end
        total++; if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", overflow); else passed++;
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 10; i++) begin
            cycle(1, 32'h100 + 32'(i), 1, 0, 0);
            total++; if (INSTRN_DATA_OUT !== 32'h100 + 32'(i)) $display("FAIL wrap_head%0d: got %h want %h", i, INSTRN_DATA_OUT, 32'h100 + 32'(i)); else passed++;
            total++; if (count !== 3'd1) $display("FAIL wrap_count%0d: got %0d want 1", i, count); else passed++;
        end
        cycle(0, 0, 1, 0, 0);
        total++; if (empty !== 1'b1 || INSTRN_DATA_OUT !== 32'h0) $display("FAIL wrap_end: got %b/%h want 1/0", empty, INSTRN_DATA_OUT); else passed++;
    endtask

    task automatic test_flush();
        for (int i = 1; i <= 3; i++) cycle(1, 32'hF0 + 32'(i), 0, 0, 0);
        total++; if (count !== 3'd3) $display("FAIL pre_flush: got %0d want 3", count); else passed++;
        cycle(1, 32'hDEAD, 0, 1, 0);
        total++; if (count !== 3'd0 || empty !== 1'b1) $display("FAIL flush: got %0d/%b want 0/1", count, empty); else passed++;
        total++; if (overflow !== ovf_m) $display("FAIL flush_ovf: got %b want %b", overflow, ovf_m); else passed++;
        cycle(1, 32'h5A, 0, 0, 0);
        total++; if (INSTRN_DATA_OUT !== 32'h5A || count !== 3'd1) $display("FAIL post_flush: got %h/%0d want 5a/1", INSTRN_DATA_OUT, count); else passed++;
        cycle(1, 32'h5B, 0, 0, 0);
    endtask

    task automatic test_reset_traffic();
        total++; if (count !== 3'd2 || overflow !== 1'b1) $display("FAIL pre_rst: got %0d/%b want 2/1", count, overflow); else passed++;
        cycle(1, 32'hBAD, 1, 1, 1);
        total++; if (count !== 3'd0 || empty !== 1'b1 || full !== 1'b0 || overflow !== 1'b0) $display("FAIL rst_traffic: got %0d/%b/%b/%b want 0/1/0/0", count, empty, full, overflow); else passed++;
        total++; if (INSTRN_DATA_OUT !== 32'h0) $display("FAIL rst_nop: got %h want 0", INSTRN_DATA_OUT); else passed++;
        cycle(1, 32'h77, 0, 0, 0);
        total++; if (INSTRN_DATA_OUT !== 32'h77 || count !== 3'd1) $display("FAIL rst_push: got %h/%0d want 77/1", INSTRN_DATA_OUT, count); else passed++;
        cycle(1, 32'h78, 1, 0, 0);
        total++; if (INSTRN_DATA_OUT !== exp_head() || count !== 3'(sb.size())) $display("FAIL rst_follow: got %h/%0d want %h/%0d", INSTRN_DATA_OUT, count, exp_head(), sb.size()); else passed++;
    endtask

    initial begin
        test_reset();
        test_fifo_order();
        test_overflow();
        test_wrap();
        test_flush();
        test_reset_traffic();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
